// File: rtl/rot_arb_ctrl.sv
// Two-requester round-robin controller for the 8-bit left rotator: load, step, capture, report.
// Define ROT_DIR_EN to add dir_a/dir_b inputs; a right rotate is converted to (WIDTH - amt) mod WIDTH left steps.
module rot_arb_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic [AW-1:0]    amt_a,
`ifdef ROT_DIR_EN
    input  logic             dir_a,
    input  logic             dir_b,
`endif
    output logic             gnt_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic [AW-1:0]    amt_b,
    output logic             gnt_b,
    output logic             rot_load,
    output logic             rot_en,
    output logic [WIDTH-1:0] rot_data,
    input  logic [WIDTH-1:0] rot_q,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             done_id,
    output logic             busy
);

    // Counter must hold WIDTH-1 once right rotates are converted to left steps.
    localparam int CW = (WIDTH > (1 << AW)) ? $clog2(WIDTH) : AW;

    typedef enum logic [1:0] {IDLE, LOAD, ROTATE, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] amt_lat;
    logic          id_lat;
    logic          last_b;
    logic          win_b;
    logic [CW-1:0] steps_a;
    logic [CW-1:0] steps_b;

    always_comb begin
        steps_a = CW'(amt_a);
        steps_b = CW'(amt_b);
`ifdef ROT_DIR_EN
        if (dir_a) steps_a = CW'((WIDTH - int'(amt_a)) % WIDTH);
        if (dir_b) steps_b = CW'((WIDTH - int'(amt_b)) % WIDTH);
`endif
    end

    // On a tie the requester that was not served last wins.
    assign win_b = req_b && (!req_a || !last_b);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            amt_lat  <= '0;
            id_lat   <= 1'b0;
            last_b   <= 1'b1;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rot_load <= 1'b0;
            rot_en   <= 1'b0;
            rot_data <= '0;
            result   <= '0;
            done     <= 1'b0;
            done_id  <= 1'b0;
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        if (win_b) begin
                            gnt_b    <= 1'b1;
                            rot_data <= data_b;
                            amt_lat  <= steps_b;
                            id_lat   <= 1'b1;
                            last_b   <= 1'b1;
                        end else begin
                            gnt_a    <= 1'b1;
                            rot_data <= data_a;
                            amt_lat  <= steps_a;
                            id_lat   <= 1'b0;
                            last_b   <= 1'b0;
                        end
                        rot_load <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    rot_load <= 1'b0;
                    cnt      <= amt_lat;
                    if (amt_lat == '0) begin
                        state <= DONE;
                    end else begin
                        rot_en <= 1'b1;
                        state  <= ROTATE;
                    end
                end
                ROTATE: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        rot_en <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    result  <= rot_q;
                    done    <= 1'b1;
                    done_id <= id_lat;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
